// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the matching Receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between user logic and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 Tx_valid;
  logic [DATA_BITS-1:0] Din;
  logic                 Tx_ready;

  modport master (output Tx_valid, output Din, input Tx_ready);
  modport slave  (input Tx_valid, input Din, output Tx_ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: bit_end marks the last clock of each bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer for gapless back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  uart_tx_if.slave   bus,
  output logic       Tx,
  output logic       Tx_busy,
  output logic       Tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  uart_state_t          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bitIdx_q;
  logic [DATA_BITS-1:0] buf_q;
  logic                 bufFull_q;
  logic                 Tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 bitEnd;
  logic                 accept;
  logic                 stopEnd;

  // Counter sits at zero while idle, so every frame starts on a full bit period.
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk_100MHz),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .bit_end (bitEnd)
  );

  assign accept       = bus.Tx_valid && !bufFull_q;
  assign stopEnd      = (state_q == STOP) && bitEnd;
  assign bus.Tx_ready = !bufFull_q;
  assign Tx           = Tx_q;
  assign Tx_busy      = busy_q;
  assign Tx_done      = done_q;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitIdx_q  <= '0;
      buf_q     <= '0;
      bufFull_q <= 1'b0;
      Tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= bus.Din;
            state_q <= START;
            Tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bitEnd) begin
            state_q  <= DATA;
            bitIdx_q <= '0;
            Tx_q     <= shift_q[0];
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitIdx_q == IDX_W'(DATA_BITS - 1)) begin
              state_q <= STOP;
              Tx_q    <= 1'b1;
            end else begin
              shift_q  <= shift_q >> 1;
              bitIdx_q <= bitIdx_q + IDX_W'(1);
              Tx_q     <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bitEnd) begin
            done_q <= 1'b1;
            if (bufFull_q) begin
              shift_q   <= buf_q;
              bufFull_q <= 1'b0;
              state_q   <= START;
              Tx_q      <= 1'b0;
            end else if (accept) begin
              shift_q <= bus.Din;
              state_q <= START;
              Tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // A byte arriving mid-frame parks in the buffer unless the stop bit is ending right now.
      if (accept && (state_q != IDLE) && !stopEnd) begin
        buf_q     <= bus.Din;
        bufFull_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame tables, back-to-back and reset sequences, random traffic.
module tb_uart_tx;

  localparam int C      = 16;
  localparam int FRAME  = 10 * C;
  localparam int NRAND  = 40;

  typedef struct {
    logic [7:0] din;
    logic [9:0] expFrame;
  } vec_t;

  logic clk_100MHz = 1'b0;
  logic rst_n      = 1'b1;
  logic tx;
  logic txBusy;
  logic txDone;

  int total = 0;
  int bad   = 0;
  int doneCount = 0;
  int framesDecoded = 0;
  int rxPhase = -1;
  logic [9:0] rxBits;
  logic [7:0] expQ[$];
  logic expLine[$];

  uart_tx_if bus ();

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .bus        (bus),
    .Tx         (tx),
    .Tx_busy    (txBusy),
    .Tx_done    (txDone)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake that completes on a rising edge is a byte that must appear on the line.
  always @(posedge clk_100MHz) begin
    if (rst_n && bus.Tx_valid === 1'b1 && bus.Tx_ready === 1'b1) begin
      expQ.push_back(bus.Din);
    end
  end

  always @(negedge clk_100MHz) begin
    if (txDone === 1'b1) doneCount++;
  end

  // Behavioural receiver: find the start bit, sample every bit at its midpoint.
  always @(negedge clk_100MHz) begin
    if (!rst_n) begin
      rxPhase = -1;
    end else begin
      if (rxPhase < 0) begin
        if (tx === 1'b0) rxPhase = 0;
      end else begin
        rxPhase = rxPhase + 1;
      end
      if (rxPhase >= 0 && (rxPhase % C) == C / 2) begin
        rxBits[rxPhase / C] = tx;
        if (rxPhase / C == 9) begin
          framesDecoded++;
          if (expQ.size() == 0) begin
            checkOutput("rx unexpected frame", 32'(rxBits[8:1]), 32'hFFFF_FFFF);
          end else begin
            checkOutput("rx byte", 32'(rxBits[8:1]), 32'(expQ.pop_front()));
          end
          checkOutput("rx start/stop", {rxBits[9], rxBits[0]}, 2'b10);
          rxPhase = -1;
        end
      end
    end
  end

  // Offer one byte at a falling edge; returns at the falling edge right after acceptance.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCnt = 0;
    bus.Tx_valid = 1'b1;
    bus.Din      = b;
    while (bus.Tx_ready !== 1'b1 && waitCnt < 3 * FRAME) begin
      @(negedge clk_100MHz);
      waitCnt++;
    end
    if (bus.Tx_ready !== 1'b1) begin
      checkOutput("ready timeout", 32'(bus.Tx_ready), 32'd1);
      bus.Tx_valid = 1'b0;
      return;
    end
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    bus.Tx_valid = 1'b0;
    bus.Din      = 8'($urandom);
  endtask

  task automatic addFrame(input logic [9:0] fr);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < C; c++) expLine.push_back(fr[b]);
    end
  endtask

  // Walks expLine cycle by cycle from the first cycle after acceptance.
  task automatic followLine(input string tag, input bit offerSecond, input logic [7:0] second);
    int lineErr = 0;
    int doneErr = 0;
    int busyErr = 0;
    int n = expLine.size();
    for (int j = 0; j < n; j++) begin
      if (offerSecond && j == 0) begin
        bus.Tx_valid = 1'b1;
        bus.Din      = second;
      end
      if (offerSecond && j == 1) begin
        checkOutput({tag, " ready drop"}, 32'(bus.Tx_ready), 32'd0);
        bus.Tx_valid = 1'b0;
        bus.Din      = 8'($urandom);
      end
      if (offerSecond && j == FRAME - 1)
        checkOutput({tag, " ready held"}, 32'(bus.Tx_ready), 32'd0);
      if (offerSecond && j == FRAME)
        checkOutput({tag, " ready back"}, 32'(bus.Tx_ready), 32'd1);
      if (tx !== expLine[j]) lineErr++;
      if (txDone !== ((j > 0 && j % FRAME == 0) ? 1'b1 : 1'b0)) doneErr++;
      if (txBusy !== 1'b1) busyErr++;
      @(negedge clk_100MHz);
    end
    checkOutput({tag, " line errors"}, 32'(lineErr), 32'd0);
    checkOutput({tag, " done errors"}, 32'(doneErr), 32'd0);
    checkOutput({tag, " busy errors"}, 32'(busyErr), 32'd0);
    checkOutput({tag, " end done"}, 32'(txDone), 32'd1);
    checkOutput({tag, " end busy"}, 32'(txBusy), 32'd0);
    checkOutput({tag, " end tx"}, 32'(tx), 32'd1);
    @(negedge clk_100MHz);
    checkOutput({tag, " done width"}, 32'(txDone), 32'd0);
    expLine.delete();
  endtask

  task automatic waitIdle(input string tag);
    int cnt = 0;
    while (!(txBusy === 1'b0 && rxPhase < 0) && cnt < 60 * FRAME) begin
      @(negedge clk_100MHz);
      cnt++;
    end
    checkOutput({tag, " idle reached"}, 32'(txBusy), 32'd0);
    @(negedge clk_100MHz);
  endtask

  initial begin
    #(2_000_000);
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    int lows, dones, f0, d0;

    // Frames in wire order: bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop.
    vecs[0] = '{8'h77, 10'h2EE};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'hA5, 10'h34A};
    vecs[4] = '{8'h5A, 10'h2B4};
    vecs[5] = '{8'h75, 10'h2EA};

    bus.Tx_valid = 1'b0;
    bus.Din      = 8'h00;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1;
    checkOutput("reset tx", 32'(tx), 32'd1);
    checkOutput("reset ready", 32'(bus.Tx_ready), 32'd1);
    checkOutput("reset busy", 32'(txBusy), 32'd0);
    checkOutput("reset done", 32'(txDone), 32'd0);
    @(negedge clk_100MHz);
    #1 rst_n = 1'b1;
    @(negedge clk_100MHz);
    checkOutput("post-reset tx", 32'(tx), 32'd1);
    checkOutput("post-reset ready", 32'(bus.Tx_ready), 32'd1);

    lows = 0;
    dones = 0;
    for (int i = 0; i < 20000; i++) begin
      if (tx !== 1'b1) lows++;
      if (txDone !== 1'b0) dones++;
      @(negedge clk_100MHz);
    end
    checkOutput("idle line low cycles", 32'(lows), 32'd0);
    checkOutput("idle done cycles", 32'(dones), 32'd0);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].din);
      addFrame(vecs[v].expFrame);
      followLine($sformatf("vec%0d", v), 1'b0, 8'h00);
      waitIdle("vec");
    end

    applyStimulus(8'h77);
    addFrame(10'h2EE);
    addFrame(10'h2EA);
    followLine("b2b", 1'b1, 8'h75);
    waitIdle("b2b");

    f0 = framesDecoded;
    d0 = doneCount;
    applyStimulus(8'h77);
    applyStimulus(8'h75);
    applyStimulus(8'h3C);
    waitIdle("third");
    checkOutput("third frames", 32'(framesDecoded - f0), 32'd3);
    checkOutput("third dones", 32'(doneCount - d0), 32'd3);
    checkOutput("third leftover", 32'(expQ.size()), 32'd0);

    applyStimulus(8'hC3);
    repeat (3 * C + 5) @(negedge clk_100MHz);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid reset tx", 32'(tx), 32'd1);
    checkOutput("mid reset busy", 32'(txBusy), 32'd0);
    checkOutput("mid reset ready", 32'(bus.Tx_ready), 32'd1);
    repeat (3) @(negedge clk_100MHz);
    #1 rst_n = 1'b1;
    expQ.delete();
    @(negedge clk_100MHz);
    applyStimulus(8'h5A);
    addFrame(10'h2B4);
    followLine("after reset", 1'b0, 8'h00);
    waitIdle("after reset");

    f0 = framesDecoded;
    for (int i = 0; i < NRAND; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk_100MHz);
      end
      applyStimulus(8'($urandom));
    end
    waitIdle("random");
    checkOutput("random frames", 32'(framesDecoded - f0), 32'(NRAND));
    checkOutput("leftover bytes", 32'(expQ.size()), 32'd0);
    checkOutput("frames vs done pulses", 32'(doneCount), 32'(framesDecoded));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
